// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: default width and
// the strobe encoding agreed between the sequencer and the datapath.
package mult_pkg;

  localparam int unsigned N_DEFAULT = 4;

  // Bit positions of the control strobes when bundled into one vector.
  localparam int unsigned NUM_STB       = 5;
  localparam int unsigned STB_CARGAQ    = 0;
  localparam int unsigned STB_RESETA    = 1;
  localparam int unsigned STB_CARGAA    = 2;
  localparam int unsigned STB_DESPLAZAQ = 3;
  localparam int unsigned STB_FIN       = 4;

  typedef logic [NUM_STB-1:0] strobe_t;

  // True for strobe combinations the datapath refuses to execute.
  function automatic logic strobes_illegal(input strobe_t s);
    logic add_and_shift;
    logic op_with_load;
    logic fin_with_other;
    add_and_shift  = s[STB_CARGAA] & s[STB_DESPLAZAQ];
    op_with_load   = (s[STB_CARGAA] | s[STB_DESPLAZAQ]) & s[STB_CARGAQ];
    fin_with_other = s[STB_FIN] & (s[STB_CARGAQ] | s[STB_RESETA] |
                                   s[STB_CARGAA] | s[STB_DESPLAZAQ]);
    return add_and_shift | op_with_load | fin_with_other;
  endfunction

endpackage

// File: rtl/mult_datapath_prod_hold.sv
// Product output register with a valid/ready handshake. A load is accepted
// when the slot is empty or is being drained in the same cycle; otherwise
// the held product is kept and the load is flagged as an overrun.
module mult_datapath_prod_hold #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         overrun
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         accept;

  // Next-state of the held product and its valid flag.
  always_comb begin
    accept  = ~valid_q | ready;
    overrun = load & ~accept;
    data_d  = data_q;
    valid_d = valid_q;
    if (load && accept) begin
      data_d  = din;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/mult_datapath.sv
// Shift-and-add multiplier datapath. Executes the one-hot strobes from the
// hardwired sequencer on the M, Q, A and C registers, returns q0 for the
// add/skip decision and publishes {A,Q} over a valid/ready handshake.
// Illegal strobe mixes, wrong shift counts and product overruns raise a
// sticky cmd_error. Requires N >= 2.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  input  logic           CargaQ,
  input  logic           ResetA,
  input  logic           CargaA,
  input  logic           DesplazaQ,
  input  logic           Fin,
  output logic           q0,
  output logic [2*N-1:0] product,
  output logic           prod_valid,
  input  logic           prod_ready,
  output logic           busy,
  output logic           cmd_error
);

  localparam logic [CW-1:0] CntFull = CW'(N);

  logic [N-1:0]  m_q, m_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  a_q, a_d;
  logic          c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  strobe_t       stb;
  logic          illegal;
  logic          publish;
  logic          overrun;
  logic [N-1:0]  a_base;
  logic          c_base;
  logic [N:0]    sum;

  // Bundle the strobes in the shared encoding and classify the mix.
  always_comb begin
    stb                = '0;
    stb[STB_CARGAQ]    = CargaQ;
    stb[STB_RESETA]    = ResetA;
    stb[STB_CARGAA]    = CargaA;
    stb[STB_DESPLAZAQ] = DesplazaQ;
    stb[STB_FIN]       = Fin;
    illegal            = strobes_illegal(stb);
  end

  // Next-state of the arithmetic registers, shift counter and flags.
  always_comb begin
    m_d     = m_q;
    q_d     = q_q;
    a_d     = a_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    err_d   = err_q;
    publish = 1'b0;
    sum     = '0;
    a_base  = a_q;
    c_base  = c_q;

    if (illegal) begin
      err_d = 1'b1;
    end else begin
      // ResetA acts first so that it composes with any legal companion.
      if (ResetA) begin
        a_base = '0;
        c_base = 1'b0;
      end
      a_d = a_base;
      c_d = c_base;

      if (CargaQ) begin
        m_d    = multiplicand;
        q_d    = multiplier;
        cnt_d  = '0;
        busy_d = 1'b1;
      end

      // CargaA and DesplazaQ are mutually exclusive once legal.
      if (CargaA) begin
        sum        = {1'b0, a_base} + {1'b0, m_q};
        {c_d, a_d} = sum;
      end

      if (DesplazaQ) begin
        q_d = {a_base[0], q_q[N-1:1]};
        a_d = {c_base, a_base[N-1:1]};
        c_d = 1'b0;
        if (cnt_q == CntFull) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      if (Fin) begin
        publish = 1'b1;
        busy_d  = 1'b0;
        if (cnt_q != CntFull || overrun) begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Datapath state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q    <= '0;
      q_q    <= '0;
      a_q    <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      m_q    <= m_d;
      q_q    <= q_d;
      a_q    <= a_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  mult_datapath_prod_hold #(
    .W (2 * N)
  ) u_prod_hold (
    .clk     (clk),
    .reset   (reset),
    .load    (publish),
    .din     ({a_q, q_q}),
    .ready   (prod_ready),
    .dout    (product),
    .valid   (prod_valid),
    .overrun (overrun)
  );

  assign q0        = q_q[0];
  assign busy      = busy_q;
  assign cmd_error = err_q;

endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Shift-and-add multiplier datapath that executes the one-hot control strobes issued by the hardwired sequencer: CargaQ, DesplazaQ, ResetA, CargaA and Fin.
- Returns q0, the current Q LSB, to the sequencer for its add/skip decision.
- Publishes the finished product to a downstream consumer over a valid/ready handshake.
- Adds protocol checking: illegal strobe combinations, wrong shift count, and product overrun.

Parameters:
- N, default 4: operand width in bits; product is 2N bits.
- CW, default $clog2(N+1): width of the internal shift counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- multiplicand  in  N  operand captured into M on CargaQ.
- multiplier  in  N  operand captured into Q on CargaQ.
- CargaQ  in  1  load Q and M, clear the shift counter.
- ResetA  in  1  clear A and carry C.
- CargaA  in  1  {C,A} <= A + M.
- DesplazaQ  in  1  shift {C,A,Q} right by one.
- Fin  in  1  end of operation; publish the product.
- q0  out  1  Q[0], combinational from the register.
- product  out  2N  held result {A,Q} captured at Fin.
- prod_valid  out  1  product available.
- prod_ready  in  1  consumer accepts the product.
- busy  out  1  operation in progress, from CargaQ until Fin.
- cmd_error  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (synchronous, active-high) clears M, Q, A, C, the shift counter, product, prod_valid, busy and cmd_error. As a result, q0 = 0.
- All register updates happen on the rising clk edge. Strobes are sampled as levels each cycle.
- CargaQ and ResetA may be asserted together (the sequencer does this in its first step):
  - M <= multiplicand, Q <= multiplier, A <= 0, C <= 0, cnt <= 0, busy <= 1.
- CargaQ alone loads M, Q and cnt, but leaves A/C unchanged. ResetA alone clears A and C.
- CargaA: {C,A} <= {1'b0,A} + {1'b0,M}, computed at N+1 bits. Q, M and cnt are unchanged.
- DesplazaQ:
  - Q <= {A[0], Q[N-1:1]}, A <= {C, A[N-1:1]}, C <= 0.
  - cnt <= cnt + 1, saturating at N.
- Illegal combinations, each of which sets cmd_error and leaves all data registers unchanged that cycle:
  - CargaA together with DesplazaQ;
  - CargaA or DesplazaQ together with CargaQ;
  - Fin together with any other strobe.
- A DesplazaQ issued with cnt == N sets cmd_error. The shift still executes.
- Fin, when prod_valid == 0 or prod_ready == 1 in the same cycle:
  - product <= {A,Q}, prod_valid <= 1, busy <= 0.
  - If cnt != N, cmd_error <= 1, but the product is still published.
- Fin when prod_valid == 1 and prod_ready == 0 (overrun):
  - The held product is not overwritten and cmd_error <= 1.
  - busy drops anyway.
  - The new result is lost.
- Handshake:
  - The transfer completes in a cycle with prod_valid && prod_ready; prod_valid then clears on the next edge unless Fin reloads it in that same cycle.
  - product stays stable while prod_valid is high and prod_ready is low.
- Strobes received while busy == 0, other than CargaQ/ResetA, still operate on the registers. This is not an error, so the sequencer may be used stand-alone.
- cmd_error is cleared only by reset.
- Reset mid-operation (busy == 1) abandons the operation with no product published.
- Latency: product appears one cycle after the Fin edge. q0 reflects the register state with zero combinational delay.

Decomposition:
- Shared package mult_pkg holds:
  - the default N;
  - the strobe bit positions as localparams (STB_CARGAQ=0, STB_RESETA=1, STB_CARGAA=2, STB_DESPLAZAQ=3, STB_FIN=4), so the sequencer and datapath agree on the same encoding when strobes are bundled.
- One natural sub-module, prod_hold: the 2N-bit output register plus its valid/ready/overrun logic.

Test Plan:
- N=4, multiplicand=5, multiplier=3. Sequence: CargaQ+ResetA, then 4×(CargaA if q0, DesplazaQ), then Fin -> product=15, prod_valid=1, cmd_error=0, q0 sequence observed 1,1,0,0.
- N=4, 15×15 with prod_ready held high -> product=225, carry path exercised (C=1 after an add), prod_valid pulses for exactly 1 cycle.
- Fin after only 3 shifts (5×3) -> product published as {A,Q}, cmd_error=1.
- CargaA and DesplazaQ asserted in the same cycle with A=2 -> A, Q and C unchanged, cmd_error=1.
- Two full multiplies with prod_ready=0 -> first product (15) held, second Fin sets cmd_error=1; after prod_ready=1 the first product is accepted and prod_valid=0.
- Reset asserted after 2 shifts -> next edge: all outputs 0, busy=0, cmd_error=0, no prod_valid.
